pow2_round_seq_unit: RTL and testbench
======================================

Name: pow2_round_seq_unit

Overview:
- Multi-cycle execute-stage unit for the round-up-to-power-of-2 ALU instruction.
- Sits between register-read and writeback, with a valid/ready handshake on each side.
- Computes the result with an MSB-first bit scan, one bit per cycle, instead of a wide priority encoder.
- Carries the destination-register tag through so writeback can retire the result.

Parameters:
- WIDTH, 8, operand/result width in bits.
- TAG_W, 3, destination-register tag width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, sampled on rising clk.
- flush  in  1  pipeline flush; aborts any operation and drops any held result.
- in_valid  in  1  operand presented by register-read.
- in_ready  out  1  unit can accept an operand.
- op1  in  WIDTH  unsigned operand.
- in_tag  in  TAG_W  destination-register tag.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback consumes the result.
- rounded  out  WIDTH  smallest power of 2 >= op1; 0 when overflowed.
- ovf  out  1  result not representable in WIDTH bits.
- out_tag  out  TAG_W  tag captured with the operand.
- busy  out  1  high in SCAN or DONE.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - rounded=0, ovf=0, out_tag=0.
  - Internal work/idx cleared.
  - rst overrides flush and all handshakes; a reset mid-SCAN or in DONE discards the operation silently.
- FSM states: IDLE, SCAN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - Accept occurs on an edge with in_valid && in_ready && !flush.
  - On accept: work = (op1==0) ? 0 : op1-1 (op1=0 never underflows); tag captured; idx=WIDTH-1; go to SCAN.
- SCAN, once per cycle:
  - work[idx]==1: if idx==WIDTH-1 then rounded=0, ovf=1; else rounded=1<<(idx+1), ovf=0. Go to DONE.
  - work[idx]==0 and idx==0 (work==0, i.e. op1 is 0 or 1): rounded=1, ovf=0. Go to DONE.
  - Otherwise: idx decrements; stay in SCAN.
- Latency, from accept edge to first edge where out_valid=1:
  - WIDTH-p, where p = MSB position of work.
  - WIDTH when work==0.
  - Range 1..WIDTH; deterministic.
- DONE:
  - rounded, ovf and out_tag are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE; in_ready rises the next cycle. No same-cycle accept; max throughput is one op per latency+2 cycles.
- rounded, ovf and out_tag are registered and change only when entering DONE. Outside DONE they hold their last values and are don't-care to consumers.
- flush=1 in any state: next state IDLE, no capture, result dropped, out_valid=0 the next cycle.
  - flush together with in_valid in IDLE: flush wins, operand not accepted.
  - flush together with out_ready in DONE: the transfer counts as having occurred; state goes to IDLE either way.
- Arithmetic: unsigned only; op1 > 2^(WIDTH-1) yields ovf=1 and rounded=0.

Decomposition:
- Shared package pow2_round_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - default WIDTH and TAG_W constants;
  - IDX_W = clog2(WIDTH).
- No sub-module; the scan step is a single inline comparison on work[idx].
- The bench uses a behavioural round-up function as its scoreboard model.

Test Plan:
- op1=5, tag=2, out_ready=1 -> out_valid 6 cycles after accept; rounded=8, ovf=0, out_tag=2.
- op1=16 then op1=17, back-to-back -> rounded=16 (latency 5), then rounded=32 (latency 4); second accept only after in_ready returns high.
- Boundaries, each -> rounded/ovf/latency:
  - op1=0 -> 1/0/8.
  - op1=1 -> 1/0/8.
  - op1=128 -> 128/0/2.
  - op1=129 -> 0/1/1.
  - op1=255 -> 0/1/1.
- op1=9 with out_ready=0 for 5 cycles after out_valid -> rounded=16 held stable and in_ready=0 throughout; returns to IDLE the cycle after out_ready=1.
- Interrupt cases:
  - flush in the 3rd SCAN cycle of op1=3 -> IDLE next cycle, out_valid never asserts.
  - rst asserted while in DONE -> all outputs at reset values next cycle.
- flush and in_valid both high in IDLE with op1=7 -> operand not accepted, state stays IDLE, busy=0.

Source files
------------

// File: rtl/pow2_round_pkg.sv
// pow2_round_pkg: shared FSM state type and sizing constants for the round-up-to-power-of-2 unit.
//   Provides: state_t {IDLE, SCAN, DONE}, WIDTH_DEF, TAG_W_DEF, IDX_W, idx_w().
package pow2_round_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int WIDTH_DEF = 8;
    localparam int TAG_W_DEF = 3;

    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

    localparam int IDX_W = idx_w(WIDTH_DEF);

endpackage

// File: rtl/pow2_round_seq_unit_if.sv
// pow2_round_seq_unit_if: operand/result handshake bundle between register-read, the unit and writeback.
//   in_valid/in_ready/op1/in_tag  : operand side (register-read drives valid/data)
//   out_valid/out_ready/rounded/ovf/out_tag : result side (writeback drives ready)
//   master = register-read/writeback side, slave = the execute unit.
interface pow2_round_seq_unit_if
    import pow2_round_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rounded;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op1, in_tag, out_ready,
        input  in_ready, out_valid, rounded, ovf, out_tag
    );

    modport slave (
        input  in_valid, op1, in_tag, out_ready,
        output in_ready, out_valid, rounded, ovf, out_tag
    );

endinterface

// File: rtl/pow2_round_seq_unit.sv
// pow2_round_seq_unit: multi-cycle round-up-to-power-of-2 execute unit using an MSB-first bit scan.
//   clk, rst : clock and synchronous active-high reset
//   flush    : aborts any operation and drops any held result
//   busy     : high while scanning or holding a result
//   bus      : slave side of the operand/result handshake bundle
module pow2_round_seq_unit
    import pow2_round_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  busy,
    pow2_round_seq_unit_if.slave  bus
);

    localparam int IW = idx_w(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [IW-1:0]    idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] rounded_q;
    logic             ovf_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
            rounded_q <= '0;
            ovf_q     <= 1'b0;
            out_tag_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    // op1-1 makes exact powers of two round to themselves; 0 is clamped to avoid wrap
                    work_q  <= (bus.op1 == '0) ? '0 : bus.op1 - WIDTH'(1);
                    tag_q   <= bus.in_tag;
                    idx_q   <= IW'(WIDTH - 1);
                    state_q <= SCAN;
                end
                SCAN: if (work_q[idx_q]) begin
                    // first set bit at p means the answer is 2^(p+1), which overflows when p is the MSB
                    rounded_q <= (idx_q == IW'(WIDTH - 1)) ? '0 : WIDTH'(1) << (idx_q + IW'(1));
                    ovf_q     <= idx_q == IW'(WIDTH - 1);
                    out_tag_q <= tag_q;
                    state_q   <= DONE;
                end else if (idx_q == '0) begin
                    rounded_q <= WIDTH'(1);
                    ovf_q     <= 1'b0;
                    out_tag_q <= tag_q;
                    state_q   <= DONE;
                end else begin
                    idx_q <= idx_q - IW'(1);
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign busy          = state_q != IDLE;
    assign bus.rounded   = rounded_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_pow2_round_seq_unit.sv
// tb_pow2_round_seq_unit: scoreboard bench for pow2_round_seq_unit with directed and random operands.
module tb_pow2_round_seq_unit;
    import pow2_round_pkg::*;

    localparam int W = 8;
    localparam int T = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy;

    pow2_round_seq_unit_if #(.WIDTH(W), .TAG_W(T)) bus ();

    pow2_round_seq_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         o;
        logic [T-1:0] t;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rmode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Smallest power of two >= op by repeated doubling; latency from the position of op-1's top bit.
    function automatic exp_t model(input int op, input int tag);
        exp_t e;
        int p = 1;
        int k = 0;
        while (p < op) p = p * 2;
        e.o = p >= (2 ** W);
        e.r = e.o ? '0 : p[W-1:0];
        e.t = tag[T-1:0];
        while ((2 ** (k + 1)) <= op - 1) k++;
        e.lat = (op <= 1) ? W : W - k;
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input int op, input int tag, input bit push);
        exp_t e;
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            @(negedge clk);
            w++;
            if (w > 200) begin
                chk("in_ready_timeout", 0, 1);
                return;
            end
        end
        bus.in_valid = 1'b1;
        bus.op1 = op[W-1:0];
        bus.in_tag = tag[T-1:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) begin
            e = model(op, tag);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (!(bus.in_ready && q.size() == 0)) begin
            @(negedge clk);
            w++;
            if (w > 300) begin
                chk("idle_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!bus.out_valid) begin
            @(negedge clk);
            w++;
            if (w > 50) begin
                chk("out_valid_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, bus.in_ready, 1);
        chk({nm, "_out_valid"}, bus.out_valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_rounded"}, bus.rounded, 0);
        chk({nm, "_ovf"}, bus.ovf, 0);
        chk({nm, "_out_tag"}, bus.out_tag, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rmode == 0) bus.out_ready = 1'b1;
            else if (rmode == 1) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops one expectation per result and checks it on every cycle it is presented.
    exp_t cur;
    int   seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !bus.out_valid) begin
                seen = 0;
            end else begin
                if (seen == 0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                        seen = 2;
                    end else begin
                        cur = q.pop_front();
                        seen = 1;
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end
                if (seen == 1) begin
                    chk("rounded", bus.rounded, cur.r);
                    chk("ovf", bus.ovf, cur.o);
                    chk("out_tag", bus.out_tag, cur.t);
                    chk("in_ready_in_done", bus.in_ready, 0);
                    chk("busy_in_done", busy, 1);
                end
            end
        end
    end

    int vals[5] = '{0, 1, 128, 129, 255};

    initial begin
        bus.in_valid = 1'b0;
        bus.op1 = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        send(5, 2, 1);
        wait_idle();

        send(16, 3, 1);
        send(17, 4, 1);
        wait_idle();

        foreach (vals[i]) send(vals[i], i, 1);
        wait_idle();

        rmode = 2;
        bus.out_ready = 1'b0;
        send(9, 5, 1);
        @(negedge clk);
        wait_valid();
        repeat (5) begin
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_out_valid", bus.out_valid, 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_out_valid", bus.out_valid, 0);

        send(3, 1, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("scan_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        repeat (10) @(negedge clk);

        bus.out_ready = 1'b0;
        send(100, 6, 1);
        @(negedge clk);
        wait_valid();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_done");
        bus.out_ready = 1'b1;
        rmode = 0;

        @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.op1 = 8'd7;
        bus.in_tag = 3'd7;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle_in_ready", bus.in_ready, 1);
        chk("flush_idle_busy", busy, 0);
        repeat (10) @(negedge clk);

        rmode = 1;
        repeat (40) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1);
        wait_idle();
        rmode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
